mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 SHALL take to_MEM_data_width, default 69 (from constants.h), as the width of the EX->MEM bus.
REQ-002 SHALL take to_WB_data_width, default 65 (from constants.h), as the width of the MEM->WB bus.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 to_MEM_data  input  to_MEM_data_width  {ld_op[2:0], res_from_mem, gr_we, dest[31:0], alu_result[31:0]}.
REQ-006 EX_to_MEM_valid  input  1  to_MEM_data holds a valid instruction.
REQ-007 MEM_allow_in  output  1  MEM accepts from EX this cycle.
REQ-008 data_sram_rdata  input  32  load data word.
REQ-009 data_sram_data_ok  input  1  data_sram_rdata valid this cycle.
REQ-010 to_WB_data  output  to_WB_data_width  {dest[31:0], final_result[31:0], gr_we}; this MSB-to-LSB order is fixed.
REQ-011 MEM_to_WB_valid  output  1  to_WB_data valid for WB.
REQ-012 WB_allow_in  input  1  WB accepts this cycle.

Function
REQ-013 SHALL hold MEM_valid; on an accepting edge (MEM_allow_in=1) MEM_valid SHALL load EX_to_MEM_valid; otherwise it SHALL hold.
REQ-014 SHALL register to_MEM_data only when EX_to_MEM_valid && MEM_allow_in; otherwise it SHALL hold.
REQ-015 MEM_allow_in SHALL be ~MEM_valid | (MEM_ready_go & WB_allow_in), combinational.
REQ-016 MEM_to_WB_valid SHALL be MEM_valid & MEM_ready_go, combinational.
REQ-017 FSM states SHALL be EMPTY (MEM_valid=0), WAIT_DATA (valid load, no data yet) and READY (result available).
REQ-018 On entry with res_from_mem=1, the state SHALL be WAIT_DATA; with res_from_mem=0, it SHALL be READY.
REQ-019 WAIT_DATA SHALL go to READY on data_sram_data_ok.
REQ-020 MEM_ready_go SHALL be 1 in READY and 1 in WAIT_DATA during a data_sram_data_ok cycle, so the load completes in the same cycle as data_ok.
REQ-021 On data_ok in WAIT_DATA, data_sram_rdata SHALL be captured into rdata_buf; READY SHALL use rdata_buf for loads.
REQ-022 Leaving READY or WAIT_DATA: handoff (MEM_to_WB_valid & WB_allow_in) with a simultaneous new acceptance SHALL re-enter per REQ-018; handoff without acceptance SHALL go to EMPTY.
REQ-023 With WB_allow_in=0, READY SHALL hold to_WB_data bit-stable, with no new acceptance.
REQ-024 data_sram_data_ok SHALL be ignored in EMPTY and READY, and for non-load instructions.
REQ-025 ld_op 000 LD.W SHALL give the full word.
REQ-026 ld_op 001 LD.B SHALL give the sign-extended byte selected by alu_result[1:0].
REQ-027 ld_op 011 LD.BU SHALL give that byte zero-extended.
REQ-028 ld_op 010 LD.H SHALL give the sign-extended halfword selected by alu_result[1].
REQ-029 ld_op 100 LD.HU SHALL give that halfword zero-extended.
REQ-030 Other ld_op values SHALL be treated as LD.W.
REQ-031 final_result SHALL be res_from_mem ? load_result : alu_result.
REQ-032 The gr_we and dest fields SHALL pass through unchanged.
REQ-033 Latency SHALL be 0 cycles after the data register for non-loads, and 0 cycles after data_ok for loads.

Reset
REQ-034 When reset=1, MEM_valid SHALL be 0, the state EMPTY, and rdata_buf 0.
REQ-035 During and after reset, outputs SHALL be MEM_to_WB_valid=0 and MEM_allow_in=1.
REQ-036 Reset during WAIT_DATA SHALL drop the instruction, and a later data_ok SHALL be ignored.
REQ-037 The registered to_MEM_data SHALL be don't-care under reset.

Verification
REQ-038 ALU op: alu_result=0x12345678, dest=5, gr_we=1, WB_allow_in=1 -> next cycle MEM_to_WB_valid=1 and to_WB_data={32'd5, 0x12345678, 1'b1}.
REQ-039 LD.B: alu_result[1:0]=3, rdata=0x80FF0000, data_ok 2 cycles after entry -> MEM_to_WB_valid stays 0 for 2 cycles, then final_result=0xFFFFFF80 in the data_ok cycle.
REQ-040 LD.HU: alu_result[1]=1, rdata=0xBEEF1234 -> final_result=0x0000BEEF.
REQ-041 Load data_ok arrives while WB_allow_in=0 for 3 cycles, rdata changed afterward -> output holds the captured value and MEM_allow_in=0 until release; exactly one handoff.
REQ-042 Back-to-back ALU ops with WB_allow_in=1 -> one instruction per cycle; toggling WB_allow_in gives no loss or duplication.
REQ-043 Reset asserted in WAIT_DATA, then data_ok pulses -> MEM_to_WB_valid stays 0 and MEM_allow_in=1.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: one-entry holding register that finishes loads and passes results to WB.
// Latency: 0 cycles after the register for ALU ops, 0 cycles after data_ok for loads; backpressure via WB_allow_in.
module mem_stage #(
    parameter int to_MEM_data_width = 69,
    parameter int to_WB_data_width  = 65
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [to_MEM_data_width-1:0] to_MEM_data,
    input  logic                         EX_to_MEM_valid,
    output logic                         MEM_allow_in,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         data_sram_data_ok,
    output logic [to_WB_data_width-1:0]  to_WB_data,
    output logic                         MEM_to_WB_valid,
    input  logic                         WB_allow_in
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_DATA = 2'd1,
        READY     = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic                          MEM_valid;
    logic                          MEM_ready_go;
    logic [to_MEM_data_width-1:0]  mem_data;
    logic [31:0]                   rdata_buf;

    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] dest;
    logic [31:0] alu_result;
    logic        in_res_from_mem;

    assign ld_op           = mem_data[68:66];
    assign res_from_mem    = mem_data[65];
    assign gr_we           = mem_data[64];
    assign dest            = mem_data[63:32];
    assign alu_result      = mem_data[31:0];
    assign in_res_from_mem = to_MEM_data[65];

    assign MEM_ready_go    = (state == READY) || ((state == WAIT_DATA) && data_sram_data_ok);
    assign MEM_allow_in    = !MEM_valid || (MEM_ready_go && WB_allow_in);
    assign MEM_to_WB_valid = MEM_valid && MEM_ready_go;

    // An accepting edge always reloads the state, whether or not something leaves.
    always_comb begin
        state_nxt = state;
        if (MEM_allow_in) begin
            if (EX_to_MEM_valid)
                state_nxt = in_res_from_mem ? WAIT_DATA : READY;
            else
                state_nxt = EMPTY;
        end else if ((state == WAIT_DATA) && data_sram_data_ok) begin
            state_nxt = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            MEM_valid <= 1'b0;
            rdata_buf <= 32'd0;
        end else begin
            state <= state_nxt;
            if (MEM_allow_in)
                MEM_valid <= EX_to_MEM_valid;
            if ((state == WAIT_DATA) && data_sram_data_ok)
                rdata_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (EX_to_MEM_valid && MEM_allow_in)
            mem_data <= to_MEM_data;
    end

    // In the data_ok cycle the word comes straight from the bus; afterwards from the buffer.
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign ld_word = (state == WAIT_DATA) ? data_sram_rdata : rdata_buf;

    always_comb begin
        case (alu_result[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        case (ld_op)
            3'b001:  load_result = {{24{ld_byte[7]}}, ld_byte};
            3'b011:  load_result = {24'd0, ld_byte};
            3'b010:  load_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_result = {16'd0, ld_half};
            default: load_result = ld_word;
        endcase
    end

    assign final_result = res_from_mem ? load_result : alu_result;
    assign to_WB_data   = {dest, final_result, gr_we};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage with a transaction-level model and queue scoreboard.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [68:0] to_MEM_data;
    logic        EX_to_MEM_valid;
    logic        MEM_allow_in;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic [64:0] to_WB_data;
    logic        MEM_to_WB_valid;
    logic        WB_allow_in;

    mem_stage #(.to_MEM_data_width(69), .to_WB_data_width(65)) dut (
        .clk              (clk),
        .reset            (reset),
        .to_MEM_data      (to_MEM_data),
        .EX_to_MEM_valid  (EX_to_MEM_valid),
        .MEM_allow_in     (MEM_allow_in),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_data_ok(data_sram_data_ok),
        .to_WB_data       (to_WB_data),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .WB_allow_in      (WB_allow_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] sb[$];

    // Instruction-level view of what MEM currently holds.
    bit          occ     = 0;
    bit          m_load  = 0;
    bit          m_got   = 0;
    int          m_cnt   = 0;
    logic [31:0] p_word  = 0;
    bit          was_rst = 0;

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (op)
            3'b001:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b011:  return b;
            3'b010:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [68:0] mk(input logic [2:0] op, input bit rfm, input bit we,
                                       input logic [31:0] dst, input logic [31:0] alu);
        return {op, rfm, we, dst, alu};
    endfunction

    // One clock of stimulus plus model update; lw/dly only matter if a load is accepted.
    task automatic cycle(input bit rst, input bit ex_v, input logic [68:0] d, input bit wb,
                         input logic [31:0] lw, input int dly);
        bit dok;
        bit avail;
        bit exp_allow;
        @(posedge clk);
        #2;
        reset           = rst;
        EX_to_MEM_valid = rst ? 1'b0 : ex_v;
        to_MEM_data     = d;
        WB_allow_in     = rst ? 1'b0 : wb;
        if (!rst && occ && m_load && !m_got && m_cnt == 0) begin
            dok             = 1;
            data_sram_rdata = p_word;
        end else if (!rst && occ && m_load && !m_got) begin
            dok             = 0;
            data_sram_rdata = $urandom;
            m_cnt--;
        end else begin
            dok             = bit'($urandom_range(0, 1));
            data_sram_rdata = $urandom;
        end
        data_sram_data_ok = dok;
        #1;
        if (rst) begin
            if (was_rst) begin
                chk("rst_allow_in", 65'(MEM_allow_in), 65'd1);
                chk("rst_valid", 65'(MEM_to_WB_valid), 65'd0);
            end
            if (occ) void'(sb.pop_back());
            occ     = 0;
            was_rst = 1;
        end else begin
            was_rst   = 0;
            avail     = occ && (!m_load || m_got || dok);
            exp_allow = !occ || (avail && wb);
            chk("allow_in", 65'(MEM_allow_in), 65'(exp_allow));
            chk("to_wb_valid", 65'(MEM_to_WB_valid), 65'(avail));
            if (avail && wb)
                occ = 0;
            else if (occ && m_load && dok)
                m_got = 1;
            if (ex_v && exp_allow) begin
                occ    = 1;
                m_load = d[65];
                m_got  = 0;
                m_cnt  = dly;
                p_word = lw;
                sb.push_back({d[63:32], d[65] ? ref_load(d[68:66], d[31:0], lw) : d[31:0], d[64]});
            end
        end
    endtask

    // Monitor: consumes handoffs and checks that a stalled output stays put.
    bit          prev_hold = 0;
    logic [64:0] prev_dat;
    logic [64:0] exp_dat;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 65'(MEM_to_WB_valid), 65'd1);
                chk("hold_data", to_WB_data, prev_dat);
            end
            if (MEM_to_WB_valid && WB_allow_in) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_handoff: got %h expected none", to_WB_data);
                end else begin
                    exp_dat = sb.pop_front();
                    chk("to_wb_data", to_WB_data, exp_dat);
                end
            end
            prev_hold = MEM_to_WB_valid && !WB_allow_in;
            prev_dat  = to_WB_data;
        end
    end

    initial begin
        reset             = 1'b1;
        EX_to_MEM_valid   = 1'b0;
        to_MEM_data       = '0;
        WB_allow_in       = 1'b0;
        data_sram_rdata   = '0;
        data_sram_data_ok = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);

        // ALU op, then LD.B with data_ok two cycles after entry, then LD.HU.
        cycle(0, 1, mk(3'b000, 0, 1, 32'd5, 32'h1234_5678), 1, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);
        cycle(0, 1, mk(3'b001, 1, 1, 32'd7, 32'h0000_1003), 1, 32'h80FF_0000, 2);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0, 0);
        cycle(0, 1, mk(3'b100, 1, 1, 32'd9, 32'h0000_2002), 1, 32'hBEEF_1234, 0);
        cycle(0, 0, '0, 1, 0, 0);

        // Load completes while WB stalls; EX keeps offering an ALU op meanwhile.
        cycle(0, 1, mk(3'b000, 1, 1, 32'd3, 32'h0000_0040), 1, 32'hCAFE_F00D, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, mk(3'b000, 0, 1, 32'd4, 32'h0000_0044), 0, 0, 0);
        cycle(0, 1, mk(3'b000, 0, 1, 32'd4, 32'h0000_0044), 1, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);

        // Back-to-back ALU ops, steady then with WB toggling.
        for (int i = 0; i < 6; i++) cycle(0, 1, mk(3'b000, 0, 1, 32'(i + 10), $urandom), 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, mk(3'b000, 0, 0, 32'(i + 20), $urandom), bit'(i % 2), 0, 0);
        cycle(0, 0, '0, 1, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);

        // Reset while a load waits; later data_ok noise must be ignored.
        cycle(0, 1, mk(3'b001, 1, 1, 32'd6, 32'h0000_0001), 1, 32'h1111_2222, 20);
        cycle(0, 0, '0, 1, 0, 0);
        cycle(1, 0, '0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle(0, bit'($urandom_range(0, 3) != 0),
                  mk(3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     $urandom, $urandom),
                  bit'($urandom_range(0, 9) < 7), $urandom, $urandom_range(0, 3));
        end
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1, 0, 0);

        chk("scoreboard_drained", 65'(sb.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
